// File: rtl/syscall_display_queue_pkg.sv
`default_nettype none
// =============================================================================
// Package  : syscall_display_pkg
// Purpose  : Shared state encoding and service-code helpers for the display queue.
// Revision : 1.0
// =============================================================================
package syscall_display_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int c_SVC_BASE_DEFAULT = 34;

    // FLUSH sits immediately after the last channel's service code.
    function automatic logic [31:0] flush_code(input int svc_base, input int num_ch);
        return 32'(svc_base + num_ch);
    endfunction

endpackage
`default_nettype wire

// File: rtl/syscall_display_queue_if.sv
`default_nettype none
// =============================================================================
// Interface : syscall_display_if
// Purpose   : CPU-side syscall inputs and display-side outputs of the queue.
// Revision  : 1.0
// =============================================================================
interface syscall_display_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 4
);
    logic                      syscall;
    logic [31:0]               r1_out;
    logic [WIDTH-1:0]          r2_out;
    logic [NUM_CH*WIDTH-1:0]   leddata;
    logic                      full;
    logic                      busy;
    logic                      overflow;
    logic [$clog2(DEPTH):0]    level;

    modport master (
        output syscall, r1_out, r2_out,
        input  leddata, full, busy, overflow, level
    );

    modport slave (
        input  syscall, r1_out, r2_out,
        output leddata, full, busy, overflow, level
    );
endinterface
`default_nettype wire

// File: rtl/syscall_display_queue_fifo.sv
`default_nettype none
// =============================================================================
// Module   : display_fifo
// Purpose  : Synchronous FIFO with registered count and single-cycle flush.
// Revision : 1.0
// =============================================================================
module display_fifo #(
    parameter int ENTRY_W = 33,
    parameter int DEPTH   = 4
) (
    input  wire logic                   clk,
    input  wire logic                   clr,
    input  wire logic                   push,
    input  wire logic                   pop,
    input  wire logic                   flush,
    input  wire logic [ENTRY_W-1:0]     wdata,
    output logic      [ENTRY_W-1:0]     rdata,
    output logic      [$clog2(DEPTH):0] count,
    output logic                        full,
    output logic                        empty
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == c_CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_do_push = push && !full && !flush;
    assign w_do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/syscall_display_queue.sv
`default_nettype none
// =============================================================================
// Module   : syscall_display_queue
// Purpose  : Queues syscall display writes and holds each on its channel output.
// Revision : 1.0
// =============================================================================
module syscall_display_queue
    import syscall_display_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int NUM_CH      = 2,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int SVC_BASE    = c_SVC_BASE_DEFAULT
) (
    input wire logic          clk,
    input wire logic          clr,
    syscall_display_if.slave  bus
);
    localparam int c_CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_ENTRY_W = c_CH_W + WIDTH;
    localparam int c_TMR_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int c_CNT_W   = $clog2(DEPTH) + 1;

    localparam logic [31:0]        c_FIRST    = 32'(SVC_BASE);
    localparam logic [31:0]        c_LAST     = 32'(SVC_BASE + NUM_CH - 1);
    localparam logic [31:0]        c_FLUSH    = flush_code(SVC_BASE, NUM_CH);
    localparam logic [c_TMR_W-1:0] c_TMR_LOAD = c_TMR_W'(HOLD_CYCLES - 1);

    logic                    w_write_req;
    logic                    w_push;
    logic                    w_flush;
    logic                    w_pop;
    logic [c_CH_W-1:0]       w_ch;
    logic [c_ENTRY_W-1:0]    w_wdata;
    logic [c_ENTRY_W-1:0]    w_rdata;
    logic [c_CNT_W-1:0]      w_count;
    logic                    w_full;
    logic                    w_empty;
    logic [c_CH_W-1:0]       w_head_ch;
    logic [WIDTH-1:0]        w_head_data;
    state_t                  r_state;
    state_t                  w_next_state;
    logic [c_TMR_W-1:0]      r_timer;
    logic [c_TMR_W-1:0]      w_next_timer;
    logic                    r_overflow;
    logic [WIDTH-1:0]        r_led [NUM_CH];
    logic [NUM_CH*WIDTH-1:0] w_led_flat;

    // Range check first, then truncate the 32-bit offset to a channel index.
    assign w_write_req = bus.syscall && (bus.r1_out >= c_FIRST) && (bus.r1_out <= c_LAST);
    assign w_flush     = bus.syscall && (bus.r1_out == c_FLUSH);
    assign w_push      = w_write_req && !w_full;
    assign w_ch        = c_CH_W'(bus.r1_out - c_FIRST);
    assign w_wdata     = {w_ch, bus.r2_out};
    assign w_head_ch   = w_rdata[c_ENTRY_W-1 -: c_CH_W];
    assign w_head_data = w_rdata[WIDTH-1:0];

    display_fifo #(
        .ENTRY_W (c_ENTRY_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_flush),
        .wdata (w_wdata),
        .rdata (w_rdata),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state <= IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_next_state;
            r_timer <= w_next_timer;
        end
    end

    // A flush on the same edge suppresses the pop; the current hold still runs out.
    always_comb begin
        w_next_state = r_state;
        w_next_timer = r_timer;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && !w_flush) begin
                    w_pop        = 1'b1;
                    w_next_timer = c_TMR_LOAD;
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                if (r_timer != '0) begin
                    w_next_timer = r_timer - 1'b1;
                end else if (!w_empty && !w_flush) begin
                    w_pop        = 1'b1;
                    w_next_timer = c_TMR_LOAD;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_overflow <= 1'b0;
        end else if (w_flush) begin
            r_overflow <= 1'b0;
        end else if (w_write_req && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_led[k] <= '0;
            end
        end else if (w_pop) begin
            r_led[w_head_ch] <= w_head_data;
        end
    end

    always_comb begin
        w_led_flat = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_led_flat[k*WIDTH +: WIDTH] = r_led[k];
        end
    end

    assign bus.leddata  = w_led_flat;
    assign bus.full     = w_full;
    assign bus.level    = w_count;
    assign bus.overflow = r_overflow;
    assign bus.busy     = (r_state == HOLD) || (w_count != '0);

endmodule
`default_nettype wire
